// File: rtl/regfile_write_queue_if.sv
// Bus bundle for the register-file write queue: request handshake, drain control,
// register-file write port, forwarding lookup and occupancy status.
interface regfile_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              InValid;
    logic              InReady;
    logic [ADDR_W-1:0] InReg;
    logic [DATA_W-1:0] InData;
    logic              HoldDrain;
    logic              WE;
    logic [ADDR_W-1:0] WReg;
    logic [DATA_W-1:0] WData;
    logic [ADDR_W-1:0] LookupReg;
    logic              LookupHit;
    logic [DATA_W-1:0] LookupData;
    logic [CNT_W-1:0]  Count;
    logic              Empty;
    logic              Full;

    modport master (
        output InValid, InReg, InData, HoldDrain, LookupReg,
        input  InReady, WE, WReg, WData, LookupHit, LookupData, Count, Empty, Full
    );

    modport slave (
        input  InValid, InReg, InData, HoldDrain, LookupReg,
        output InReady, WE, WReg, WData, LookupHit, LookupData, Count, Empty, Full
    );
endinterface

// File: rtl/regfile_write_queue.sv
// Buffers register writes in a FIFO, drains one per cycle to the register file
// and forwards the youngest pending value for any register decode asks about.
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input logic                  Clk,
    input logic                  Reset,
    regfile_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign accept = bus.InValid && !full;
    // Writes to the zero register complete the handshake but never occupy a slot.
    assign push   = accept && (bus.InReg != ZERO_REG);
    assign pop    = !empty && !bus.HoldDrain;

    assign bus.InReady = !full;
    assign bus.Count   = count;
    assign bus.Empty   = empty;
    assign bus.Full    = full;
    assign bus.WE      = pop;
    assign bus.WReg    = pop ? addrMem[head] : '0;
    assign bus.WData   = pop ? dataMem[head] : '0;

    always_ff @(posedge Clk) begin
        if (push) begin
            addrMem[tail] <= bus.InReg;
            dataMem[tail] <= bus.InData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
        bus.LookupHit  = 1'b0;
        bus.LookupData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (bus.LookupReg != ZERO_REG) &&
                (addrMem[head + PTR_W'(i)] == bus.LookupReg)) begin
                bus.LookupHit  = 1'b1;
                bus.LookupData = dataMem[head + PTR_W'(i)];
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with a per-cycle scoreboard model of
// queue contents, drain order, handshake and forwarding lookup.
module tb_regfile_write_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } entry_t;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    entry_t sb[$];
    int     modelCount;
    bit     armed;
    bit     expWe;
    bit     expReady;
    bit     expHit;
    logic [DATA_W-1:0] expData;
    entry_t front;

    regfile_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] r,
                                 input logic [DATA_W-1:0] d, input logic hold);
        @(posedge Clk);
        #1;
        bus.InValid   = valid;
        bus.InReg     = r;
        bus.InData    = d;
        bus.HoldDrain = hold;
    endtask

    // Scoreboard: predicts every output each cycle from the queue model, then
    // retires the head on a drain and enqueues the request the DUT should accept.
    always @(negedge Clk) begin
        if (armed) begin
            expReady = (modelCount != DEPTH);
            expWe    = (modelCount != 0) && !bus.HoldDrain;
            expHit   = 1'b0;
            expData  = '0;
            foreach (sb[i]) begin
                if (sb[i].r == bus.LookupReg && bus.LookupReg != 5'd31) begin
                    expHit  = 1'b1;
                    expData = sb[i].d;
                end
            end
            checkOutput("InReady", 64'(bus.InReady), 64'(expReady));
            checkOutput("WE", 64'(bus.WE), 64'(expWe));
            checkOutput("Count", 64'(bus.Count), 64'(modelCount));
            checkOutput("Empty", 64'(bus.Empty), 64'(modelCount == 0));
            checkOutput("Full", 64'(bus.Full), 64'(modelCount == DEPTH));
            checkOutput("LookupHit", 64'(bus.LookupHit), 64'(expHit));
            checkOutput("LookupData", bus.LookupData, expData);
            if (expWe) begin
                front = sb.pop_front();
                checkOutput("WReg", 64'(bus.WReg), 64'(front.r));
                checkOutput("WData", bus.WData, front.d);
                modelCount--;
            end else begin
                checkOutput("WRegIdle", 64'(bus.WReg), 64'd0);
                checkOutput("WDataIdle", bus.WData, 64'd0);
            end
            if (bus.InValid && expReady && bus.InReg != 5'd31) begin
                sb.push_back('{r: bus.InReg, d: bus.InData});
                modelCount++;
            end
        end
        if (Reset) begin
            sb.delete();
            modelCount = 0;
            armed      = 1'b1;
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        modelCount    = 0;
        armed         = 1'b0;
        Reset         = 1'b1;
        bus.InValid   = 1'b0;
        bus.InReg     = '0;
        bus.InData    = '0;
        bus.HoldDrain = 1'b0;
        bus.LookupReg = '0;

        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        checkOutput("rstWE", 64'(bus.WE), 64'd0);
        checkOutput("rstReady", 64'(bus.InReady), 64'd1);
        checkOutput("rstEmpty", 64'(bus.Empty), 64'd1);
        checkOutput("rstCount", 64'(bus.Count), 64'd0);

        // Single write goes straight through.
        applyStimulus(1, 5'd3, 64'hA5, 0);
        applyStimulus(0, 5'd0, 64'h0, 0);
        @(negedge Clk);
        checkOutput("t1WE", 64'(bus.WE), 64'd1);
        checkOutput("t1WReg", 64'(bus.WReg), 64'd3);
        checkOutput("t1WData", bus.WData, 64'hA5);
        checkOutput("t1Count", 64'(bus.Count), 64'd1);
        applyStimulus(0, 5'd0, 64'h0, 0);
        @(negedge Clk);
        checkOutput("t1Idle", 64'(bus.WE), 64'd0);
        checkOutput("t1Empty", 64'(bus.Empty), 64'd1);

        // Fill to full while holding, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, ADDR_W'(i), DATA_W'(10 * i), 1);
        end
        applyStimulus(1, 5'd5, 64'd50, 1);
        @(negedge Clk);
        checkOutput("t2Full", 64'(bus.Full), 64'd1);
        checkOutput("t2Ready", 64'(bus.InReady), 64'd0);
        checkOutput("t2Count", 64'(bus.Count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 5'd0, 64'h0, 0);
            @(negedge Clk);
            checkOutput("t2DrainWE", 64'(bus.WE), 64'd1);
            checkOutput("t2DrainReg", 64'(bus.WReg), 64'(i));
            checkOutput("t2DrainData", bus.WData, 64'(10 * i));
            if (i == 1) begin
                checkOutput("t2ReadyWhilePop", 64'(bus.InReady), 64'd0);
            end
        end
        applyStimulus(0, 5'd0, 64'h0, 0);
        @(negedge Clk);
        checkOutput("t2Empty", 64'(bus.Empty), 64'd1);

        // Forwarding picks the youngest duplicate.
        applyStimulus(1, 5'd5, 64'h1, 1);
        applyStimulus(1, 5'd5, 64'h2, 1);
        applyStimulus(1, 5'd7, 64'h3, 1);
        applyStimulus(0, 5'd0, 64'h0, 1);
        bus.LookupReg = 5'd5;
        @(negedge Clk);
        checkOutput("t3Hit5", 64'(bus.LookupHit), 64'd1);
        checkOutput("t3Data5", bus.LookupData, 64'h2);
        #1 bus.LookupReg = 5'd6;
        #1;
        checkOutput("t3Hit6", 64'(bus.LookupHit), 64'd0);
        checkOutput("t3Data6", bus.LookupData, 64'h0);
        bus.LookupReg = 5'd7;
        #1;
        checkOutput("t3Data7", bus.LookupData, 64'h3);
        repeat (4) applyStimulus(0, 5'd0, 64'h0, 0);

        // Zero-register write is accepted and dropped.
        applyStimulus(1, 5'd31, 64'hFFFF, 0);
        bus.LookupReg = 5'd31;
        @(negedge Clk);
        checkOutput("t4Ready", 64'(bus.InReady), 64'd1);
        applyStimulus(0, 5'd0, 64'h0, 0);
        @(negedge Clk);
        checkOutput("t4Count", 64'(bus.Count), 64'd0);
        checkOutput("t4WE", 64'(bus.WE), 64'd0);
        checkOutput("t4Hit31", 64'(bus.LookupHit), 64'd0);

        // Simultaneous push and pop with one entry queued.
        applyStimulus(1, 5'd8, 64'h88, 1);
        applyStimulus(1, 5'd9, 64'h99, 0);
        @(negedge Clk);
        checkOutput("t5PopReg", 64'(bus.WReg), 64'd8);
        applyStimulus(0, 5'd0, 64'h0, 0);
        @(negedge Clk);
        checkOutput("t5Count", 64'(bus.Count), 64'd1);
        checkOutput("t5WReg", 64'(bus.WReg), 64'd9);
        checkOutput("t5WData", bus.WData, 64'h99);
        applyStimulus(0, 5'd0, 64'h0, 0);

        // Reset mid-operation discards pending writes.
        applyStimulus(1, 5'd10, 64'hA, 1);
        applyStimulus(1, 5'd11, 64'hB, 1);
        applyStimulus(1, 5'd12, 64'hC, 1);
        applyStimulus(0, 5'd0, 64'h0, 1);
        Reset = 1'b1;
        applyStimulus(0, 5'd0, 64'h0, 0);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("t6Count", 64'(bus.Count), 64'd0);
        checkOutput("t6Empty", 64'(bus.Empty), 64'd1);
        checkOutput("t6WE", 64'(bus.WE), 64'd0);
        for (int i = 10; i <= 12; i++) begin
            #1 bus.LookupReg = ADDR_W'(i);
            #1;
            checkOutput("t6Hit", 64'(bus.LookupHit), 64'd0);
        end
        repeat (3) applyStimulus(0, 5'd0, 64'h0, 0);
        @(negedge Clk);
        #1;
        checkOutput("sbDrained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
